// File: rtl/nand_chk_pkg.sv
// Shared types and constants for the NAND stimulus/checker slice.
// Holds the FSM states, the Gray-ordered vector table and the NAND reference function.
package nand_chk_pkg;

    localparam int unsigned NUM_VEC = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned ERR_W   = 3;

    localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(7);

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        WAIT,
        SETTLE,
        NEXT,
        DONE
    } state_e;

    // One stimulus entry: gate inputs plus the output the gate must produce.
    typedef struct packed {
        logic a;
        logic b;
        logic expected;
    } vec_t;

    // Gray order, one input toggles per step: 00, 01, 11, 10.
    localparam vec_t [NUM_VEC-1:0] VEC_TABLE = {
        vec_t'(3'b101),
        vec_t'(3'b110),
        vec_t'(3'b011),
        vec_t'(3'b001)
    };

    function automatic logic exp_nand(input logic a, input logic b);
        return ~(a & b);
    endfunction

endpackage

// File: rtl/nand_stim_checker_if.sv
// Stimulus/response bundle between the NAND checker and its surrounding bench.
// slave is the checker side; master is whoever pulses start and provides the gate output.
interface nand_stim_checker_if
    import nand_chk_pkg::*;
#(
    parameter int unsigned LAT_W = 5
);

    logic             start;
    logic             a;
    logic             b;
    logic             out_obs;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [IDX_W-1:0] vec_idx;
    logic             lat_valid;
    logic [LAT_W-1:0] lat_value;

    modport master (
        output start,
        output out_obs,
        input  a,
        input  b,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  vec_idx,
        input  lat_valid,
        input  lat_value
    );

    modport slave (
        input  start,
        input  out_obs,
        output a,
        output b,
        output busy,
        output done,
        output pass,
        output err_count,
        output vec_idx,
        output lat_valid,
        output lat_value
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser with a selectable asynchronous reset value.
// Used to bring an asynchronous gate output into the bench clock domain.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/nand_stim_checker.sv
// Drives a 2-input NAND through a Gray vector sequence, checks its resynchronised
// output, reports per-vector response latency and counts value/timeout/glitch errors.
module nand_stim_checker
    import nand_chk_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned LAT_W          = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nand_stim_checker_if.slave   bus
);

    localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_e           state_q;
    logic             a_q;
    logic             b_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [ERR_W-1:0] err_q;
    logic [IDX_W-1:0] idx_q;
    logic             lat_valid_q;
    logic [LAT_W-1:0] lat_value_q;
    logic [LAT_W-1:0] lat_cnt_q;
    logic [SET_W-1:0] settle_cnt_q;

    logic [ERR_W-1:0] err_d;
    logic [LAT_W-1:0] lat_cnt_d;
    logic [SET_W-1:0] settle_cnt_d;
    logic [IDX_W-1:0] idx_d;
    logic             out_sync;
    vec_t             cur_vec;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus.out_obs),
        .q_o   (out_sync)
    );

    assign cur_vec      = VEC_TABLE[idx_q];
    assign err_d        = (err_q == ERR_MAX) ? err_q : err_q + ERR_W'(1);
    assign lat_cnt_d    = lat_cnt_q + LAT_W'(1);
    assign settle_cnt_d = settle_cnt_q + SET_W'(1);
    assign idx_d        = idx_q + IDX_W'(1);

    // Sequencer: apply vector, wait for match or timeout, then watch for glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a_q          <= 1'b0;
            b_q          <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            idx_q        <= '0;
            lat_valid_q  <= 1'b0;
            lat_value_q  <= '0;
            lat_cnt_q    <= '0;
            settle_cnt_q <= '0;
        end else begin
            done_q      <= 1'b0;
            lat_valid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        err_q   <= '0;
                        pass_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        idx_q   <= '0;
                        state_q <= APPLY;
                    end
                end

                APPLY: begin
                    a_q       <= cur_vec.a;
                    b_q       <= cur_vec.b;
                    lat_cnt_q <= '0;
                    state_q   <= WAIT;
                end

                WAIT: begin
                    lat_cnt_q <= lat_cnt_d;
                    // Two cycles of latency are the synchroniser flushing the old value.
                    if (lat_cnt_q >= LAT_W'(2)) begin
                        if (out_sync == cur_vec.expected) begin
                            lat_value_q  <= lat_cnt_q;
                            lat_valid_q  <= 1'b1;
                            settle_cnt_q <= '0;
                            state_q      <= SETTLE;
                        end else if (lat_cnt_q == LAT_W'(TIMEOUT_CYCLES)) begin
                            err_q       <= err_d;
                            lat_value_q <= LAT_W'(TIMEOUT_CYCLES);
                            lat_valid_q <= 1'b1;
                            state_q     <= NEXT;
                        end
                    end
                end

                SETTLE: begin
                    if (out_sync != cur_vec.expected) begin
                        err_q   <= err_d;
                        state_q <= NEXT;
                    end else if (settle_cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
                        state_q <= NEXT;
                    end else begin
                        settle_cnt_q <= settle_cnt_d;
                    end
                end

                NEXT: begin
                    if (idx_q == IDX_W'(NUM_VEC - 1)) begin
                        state_q <= DONE;
                    end else begin
                        idx_q   <= idx_d;
                        state_q <= APPLY;
                    end
                end

                DONE: begin
                    done_q  <= 1'b1;
                    pass_q  <= (err_q == '0);
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.vec_idx   = idx_q;
    assign bus.lat_valid = lat_valid_q;
    assign bus.lat_value = lat_value_q;

endmodule
